// File: rtl/adder_pkg.sv
// Shared definitions for the multi-cycle adder: FSM state encoding and
// sizing helpers used by the top level.
package adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Width of the chunk index counter; a single-chunk adder still needs one bit.
    function automatic int unsigned idx_width(input int unsigned nchunk);
        return (nchunk <= 32'd1) ? 32'd1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/multi_cycle_adder_if.sv
// Start/ready/done handshake plus operand and result bus of the multi-cycle adder.
interface multi_cycle_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, a, b, c_in,
        input  ready, busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, a, b, c_in,
        output ready, busy, done, sum, c_out, ovf
    );
endinterface

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice: {c_out, sum} = x + y + c_in.
module adder_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out
);
    logic [CHUNK:0] total_s;

    // One extra bit captures the carry out of the slice.
    always_comb begin
        total_s = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c_in};
        sum     = total_s[CHUNK-1:0];
        c_out   = total_s[CHUNK];
    end
endmodule

// File: rtl/multi_cycle_adder.sv
// WIDTH-bit adder that processes CHUNK bits per clock, rippling the carry
// through a register; results appear only when the whole word is done.
module multi_cycle_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic                clk,
    input  logic                rst,
    multi_cycle_adder_if.slave  bus
);
    localparam int unsigned     NCHUNK   = (CHUNK == 32'd0) ? 32'd1 : (WIDTH / CHUNK);
    localparam int unsigned     IDXW     = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 32'd1);

    if ((CHUNK < 32'd1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 32'd0)) begin : g_bad_params
        $error("multi_cycle_adder: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
    end

    state_e                         state_q, state_d;
    logic [IDXW-1:0]                idx_q, idx_d;
    logic                           carry_q, carry_d;
    logic [NCHUNK-1:0][CHUNK-1:0]   a_w_q, a_w_d;
    logic [NCHUNK-1:0][CHUNK-1:0]   b_w_q, b_w_d;
    logic [NCHUNK-1:0][CHUNK-1:0]   sum_w_q, sum_w_d;
    logic [WIDTH-1:0]               sum_q, sum_d;
    logic                           c_out_q, c_out_d;
    logic                           ovf_q, ovf_d;
    logic [CHUNK-1:0]               part_s;
    logic                           carry_next_s;
    logic                           a_msb_s, b_msb_s;

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x     (a_w_q[idx_q]),
        .y     (b_w_q[idx_q]),
        .c_in  (carry_q),
        .sum   (part_s),
        .c_out (carry_next_s)
    );

    assign a_msb_s = a_w_q[NCHUNK-1][CHUNK-1];
    assign b_msb_s = b_w_q[NCHUNK-1][CHUNK-1];

    // Next-state logic: operand capture, per-chunk accumulation, result load.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_w_d   = a_w_q;
        b_w_d   = b_w_q;
        sum_w_d = sum_w_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    a_w_d   = bus.a;
                    b_w_d   = bus.b;
                    carry_d = bus.c_in;
                    idx_d   = '0;
                    sum_w_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_w_d[idx_q] = part_s;
                carry_d        = carry_next_s;
                if (idx_q == LAST_IDX) begin
                    // Publish the complete word at once; partial sums never leak out.
                    state_d = S_DONE;
                    idx_d   = '0;
                    sum_d   = sum_w_d;
                    c_out_d = carry_next_s;
                    ovf_d   = (a_msb_s == b_msb_s) && (sum_d[WIDTH-1] != a_msb_s);
                end else begin
                    state_d = S_RUN;
                    idx_d   = idx_q + IDXW'(1'b1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_w_q   <= '0;
            b_w_q   <= '0;
            sum_w_q <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_w_q   <= a_w_d;
            b_w_q   <= b_w_d;
            sum_w_q <= sum_w_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake status decoded from the registered state.
    always_comb begin
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state_q)
            S_IDLE:  bus.ready = 1'b1;
            S_RUN:   bus.busy  = 1'b1;
            S_DONE:  bus.done  = 1'b1;
            default: bus.ready = 1'b0;
        endcase
        bus.sum   = sum_q;
        bus.c_out = c_out_q;
        bus.ovf   = ovf_q;
    end
endmodule

// File: tb/tb_multi_cycle_adder.sv
// Self-checking bench: three adder configurations driven in parallel and
// compared against an arithmetic reference model.
module tb_multi_cycle_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_cycle_adder_if #(.WIDTH(32)) if0 ();
    multi_cycle_adder_if #(.WIDTH(32)) if1 ();
    multi_cycle_adder_if #(.WIDTH(8))  if2 ();

    multi_cycle_adder #(.WIDTH(32), .CHUNK(8))  u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    multi_cycle_adder #(.WIDTH(32), .CHUNK(32)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    multi_cycle_adder #(.WIDTH(8),  .CHUNK(1))  u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    int wid [3] = '{32, 32, 8};
    int nch [3] = '{4, 1, 8};

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] r_sum  [3];
    logic        r_cout [3];
    logic        r_ovf  [3];
    int          r_lat  [3];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic; overflow = true signed result out of range.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        longint md, half, ua, ub, s, sa, sb, ss;
        logic   ov, co;
        logic [31:0] sm;
        md   = 64'sd1 <<< w;
        half = md / 64'sd2;
        ua   = {32'd0, a} % md;
        ub   = {32'd0, b} % md;
        s    = ua + ub + longint'(cin);
        sa   = (ua >= half) ? ua - md : ua;
        sb   = (ub >= half) ? ub - md : ub;
        ss   = sa + sb + longint'(cin);
        ov   = (ss >= half) || (ss < -half);
        co   = (s >= md);
        sm   = 32'(s % md);
        return {ov, co, sm};
    endfunction

    task automatic drive(input int d, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic cin);
        case (d)
            0: begin if0.start = s; if0.a = a; if0.b = b; if0.c_in = cin; end
            1: begin if1.start = s; if1.a = a; if1.b = b; if1.c_in = cin; end
            default: begin if2.start = s; if2.a = a[7:0]; if2.b = b[7:0]; if2.c_in = cin; end
        endcase
    endtask

    task automatic sample(input int d, output logic dn, output logic rd, output logic bs,
                          output logic [31:0] sm, output logic co, output logic ov);
        case (d)
            0: begin dn = if0.done; rd = if0.ready; bs = if0.busy; sm = if0.sum; co = if0.c_out; ov = if0.ovf; end
            1: begin dn = if1.done; rd = if1.ready; bs = if1.busy; sm = if1.sum; co = if1.c_out; ov = if1.ovf; end
            default: begin dn = if2.done; rd = if2.ready; bs = if2.busy; sm = {24'd0, if2.sum}; co = if2.c_out; ov = if2.ovf; end
        endcase
    endtask

    // One operation on all three adders at once; called #1 after a rising edge with all idle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input string tag);
        int ndone [3];
        logic rdy_after [3];
        logic busy1 [3];
        logic dn, rd, bs, co, ov;
        logic [31:0] sm;
        logic [33:0] m;
        for (int d = 0; d < 3; d++) begin
            drive(d, 1'b1, a, b, cin);
            ndone[d] = 0; r_lat[d] = 0; rdy_after[d] = 1'b0; busy1[d] = 1'b0;
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, ~a, ~b, ~cin);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                sample(d, dn, rd, bs, sm, co, ov);
                if (k == 1) busy1[d] = bs;
                if (dn) begin
                    ndone[d]++;
                    if (ndone[d] == 1) begin
                        r_lat[d] = k; r_sum[d] = sm; r_cout[d] = co; r_ovf[d] = ov;
                    end
                end
                if ((r_lat[d] != 0) && (k == r_lat[d] + 1)) rdy_after[d] = rd;
            end
        end
        for (int d = 0; d < 3; d++) begin
            m = ref_add(wid[d], a, b, cin);
            check_eq($sformatf("%s.d%0d.busy", tag, d), 64'(busy1[d] || (nch[d] == 1)), 64'd1);
            check_eq($sformatf("%s.d%0d.lat", tag, d), 64'(r_lat[d]), 64'(nch[d]));
            check_eq($sformatf("%s.d%0d.ndone", tag, d), 64'(ndone[d]), 64'd1);
            check_eq($sformatf("%s.d%0d.sum", tag, d), 64'(r_sum[d]), 64'(m[31:0]));
            check_eq($sformatf("%s.d%0d.cout", tag, d), 64'(r_cout[d]), 64'(m[32]));
            check_eq($sformatf("%s.d%0d.ovf", tag, d), 64'(r_ovf[d]), 64'(m[33]));
            check_eq($sformatf("%s.d%0d.ready", tag, d), 64'(rdy_after[d]), 64'd1);
        end
    endtask

    initial begin
        logic [33:0] mx, my;
        int ndn, d1, d2;
        logic [31:0] s1, s2;
        logic [31:0] ra, rb;
        logic rc;

        rst = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.ready", 64'(if0.ready), 64'd1);
        check_eq("rst.busy", 64'(if0.busy), 64'd0);
        check_eq("rst.done", 64'(if0.done), 64'd0);
        check_eq("rst.sum", 64'(if0.sum), 64'd0);
        check_eq("rst.sum8", 64'(if2.sum), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with hard-coded expectations for the 32/8 adder.
        do_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, "t1");
        check_eq("t1.sum", 64'(r_sum[0]), 64'h0);
        check_eq("t1.cout", 64'(r_cout[0]), 64'd1);
        check_eq("t1.ovf", 64'(r_ovf[0]), 64'd0);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "t2a");
        check_eq("t2a.sum", 64'(r_sum[0]), 64'h8000_0000);
        check_eq("t2a.ovf", 64'(r_ovf[0]), 64'd1);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, "t2b");
        check_eq("t2b.sum", 64'(r_sum[0]), 64'h0);
        check_eq("t2b.cout", 64'(r_cout[0]), 64'd1);
        check_eq("t2b.ovf", 64'(r_ovf[0]), 64'd1);
        do_op(32'h00FF_FFFF, 32'h0, 1'b1, "t3a");
        check_eq("t3a.sum", 64'(r_sum[0]), 64'h0100_0000);
        check_eq("t3a.cout", 64'(r_cout[0]), 64'd0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "t3b");
        check_eq("t3b.sum", 64'(r_sum[0]), 64'hFFFF_FFFF);
        check_eq("t3b.cout", 64'(r_cout[0]), 64'd1);
        check_eq("t3b.ovf", 64'(r_ovf[0]), 64'd0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "t6a");
        check_eq("t6a.sum32", 64'(r_sum[1]), 64'h0);
        check_eq("t6a.cout32", 64'(r_cout[1]), 64'd1);
        do_op(32'h0000_007F, 32'h0000_0001, 1'b0, "t6b");
        check_eq("t6b.sum8", 64'(r_sum[2]), 64'h80);
        check_eq("t6b.ovf8", 64'(r_ovf[2]), 64'd1);

        // Handshake: start held high; X taken first, Y on the first IDLE edge.
        mx = ref_add(32, 32'h1234_5678, 32'h1111_1111, 1'b0);
        my = ref_add(32, 32'h8000_0000, 32'h8000_0001, 1'b0);
        drive(0, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0);
        ndn = 0; d1 = -1; d2 = -1; s1 = 32'd0; s2 = 32'd0;
        for (int k = 0; k <= 13; k++) begin
            @(posedge clk); #1;
            if (k == 0) drive(0, 1'b1, 32'h8000_0000, 32'h8000_0001, 1'b0);
            if (k == 6) drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
            if (if0.done) begin
                ndn++;
                if (ndn == 1) begin d1 = k; s1 = if0.sum; end
                if (ndn == 2) begin d2 = k; s2 = if0.sum; end
            end
        end
        check_eq("t4.ndone", 64'(ndn), 64'd2);
        check_eq("t4.first_at", 64'(d1), 64'd4);
        check_eq("t4.gap", 64'(d2 - d1), 64'd6);
        check_eq("t4.sumX", 64'(s1), 64'(mx[31:0]));
        check_eq("t4.sumY", 64'(s2), 64'(my[31:0]));

        // Reset in the second RUN cycle aborts without a done pulse.
        drive(0, 1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("t5.sum", 64'(if0.sum), 64'd0);
        check_eq("t5.cout", 64'(if0.c_out), 64'd0);
        check_eq("t5.ovf", 64'(if0.ovf), 64'd0);
        check_eq("t5.busy", 64'(if0.busy), 64'd0);
        check_eq("t5.ready", 64'(if0.ready), 64'd1);
        drive(0, 1'b1, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        ndn = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (if0.done) ndn++;
        end
        check_eq("t5.nodone", 64'(ndn), 64'd0);
        do_op(32'd3, 32'd4, 1'b0, "t5b");
        check_eq("t5b.sum", 64'(r_sum[0]), 64'd7);

        // Random operands against the reference model.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            do_op(ra, rb, rc, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
